// File: rtl/int_clock_monitor_if.sv
// Signal bundle between the internal-clock frequency monitor and its status/CSR consumer.
// Handshake: there is no backpressure. meas_strobe is a valid-only pulse, high for exactly one
// clk_10mhz_ext_bufg cycle whenever meas_count and the window flags have been refreshed; the
// consumer must sample on that cycle. All other outputs are levels that are valid at any time.
interface int_clock_monitor_if #(
  parameter int COUNT_WIDTH = 16,
  parameter int HYST_BITS   = 4
) ();
  logic                   int_div_toggle;
  logic                   enable;
  logic [COUNT_WIDTH-1:0] meas_count;
  logic                   meas_strobe;
  logic                   int_freq_ok;
  logic                   int_freq_low;
  logic                   int_freq_high;
  logic                   int_clk_stopped;
  logic [HYST_BITS-1:0]   hyst_count;
  logic [1:0]             fsm_state;

  // master: the block that drives the toggle/enable and consumes the status
  modport master (
    output int_div_toggle, enable,
    input  meas_count, meas_strobe, int_freq_ok, int_freq_low, int_freq_high,
           int_clk_stopped, hyst_count, fsm_state
  );

  // slave: the monitor itself
  modport slave (
    input  int_div_toggle, enable,
    output meas_count, meas_strobe, int_freq_ok, int_freq_low, int_freq_high,
           int_clk_stopped, hyst_count, fsm_state
  );
endinterface

// File: rtl/int_clock_monitor.sv
// Checks the 250 MHz internal clock against the 10 MHz external reference by counting
// transitions of a divide-by-64 toggle over a fixed gate, with windowed thresholds and
// a hysteresis counter deciding int_freq_ok. fsm_state exposes the FSM for debug.
module int_clock_monitor #(
  parameter int GATE_LOG2   = 10,
  parameter int EXPECTED    = 400,
  parameter int TOL_IN      = 2,
  parameter int TOL_OUT     = 4,
  parameter int HYST_BITS   = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic               clk_10mhz_ext_bufg,
  input  logic               rst_250mhz_int,
  int_clock_monitor_if.slave mon
);

  localparam logic [1:0] DISABLED = 2'd0;
  localparam logic [1:0] SETTLE   = 2'd1;
  localparam logic [1:0] MEASURE  = 2'd2;

  localparam logic [COUNT_WIDTH-1:0]     CNT_MAX   = '1;
  localparam logic [HYST_BITS-1:0]       HYST_MAX  = '1;
  localparam logic signed [COUNT_WIDTH:0] EXP_S     = (COUNT_WIDTH+1)'(EXPECTED);
  localparam logic signed [COUNT_WIDTH:0] TOL_IN_S  = (COUNT_WIDTH+1)'(TOL_IN);
  localparam logic signed [COUNT_WIDTH:0] TOL_OUT_S = (COUNT_WIDTH+1)'(TOL_OUT);

  logic [2:0]             sync_q;
  logic [1:0]             state;
  logic [GATE_LOG2-1:0]   gate_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt;
  logic [COUNT_WIDTH-1:0] meas_q;
  logic                   strobe_q;
  logic                   ok_q;
  logic                   low_q;
  logic                   high_q;
  logic                   stop_q;
  logic [HYST_BITS-1:0]   hyst_q;

  logic                   edge_seen;
  logic                   gate_term;
  logic [COUNT_WIDTH-1:0] closing_count;
  logic signed [COUNT_WIDTH:0] diff;
  logic signed [COUNT_WIDTH:0] diff_abs;
  logic                   win_good;
  logic                   win_bad;
  logic                   win_low;
  logic                   win_high;
  logic                   win_stop;

  // Window classification; the closing count includes an edge landing on the terminal cycle.
  always_comb begin
    edge_seen     = sync_q[2] ^ sync_q[1];
    gate_term     = &gate_cnt;
    closing_count = (edge_cnt == CNT_MAX) ? CNT_MAX : edge_cnt + COUNT_WIDTH'(edge_seen);
    diff          = $signed({1'b0, closing_count}) - EXP_S;
    diff_abs      = diff[COUNT_WIDTH] ? -diff : diff;
    win_good      = (diff_abs <= TOL_IN_S);
    win_bad       = (diff_abs > TOL_OUT_S);
    win_low       = (diff < -TOL_OUT_S);
    win_high      = (diff > TOL_OUT_S);
    win_stop      = (closing_count == '0);
  end

  // Three-flop synchronizer for the asynchronous divided toggle.
  always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_250mhz_int) begin
    if (rst_250mhz_int) sync_q <= '0;
    else                sync_q <= {sync_q[1:0], mon.int_div_toggle};
  end

  // FSM plus gate and saturating edge counters; the first gate after enable is a discarded settle.
  always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_250mhz_int) begin
    if (rst_250mhz_int) begin
      state    <= DISABLED;
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (!mon.enable) begin
      state    <= DISABLED;
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else begin
      case (state)
        DISABLED: state <= SETTLE;
        SETTLE, MEASURE: begin
          gate_cnt <= gate_cnt + 1'b1;
          if (gate_term) begin
            edge_cnt <= '0;
            state    <= MEASURE;
          end else begin
            edge_cnt <= closing_count;
          end
        end
        default: state <= DISABLED;
      endcase
    end
  end

  // Report each completed measurement window and run the hysteresis decision.
  always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_250mhz_int) begin
    if (rst_250mhz_int) begin
      meas_q   <= '0;
      strobe_q <= 1'b0;
      ok_q     <= 1'b0;
      low_q    <= 1'b0;
      high_q   <= 1'b0;
      stop_q   <= 1'b0;
      hyst_q   <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (!mon.enable) begin
        hyst_q <= '0;
        ok_q   <= 1'b0;
      end else if (state == MEASURE && gate_term) begin
        meas_q   <= closing_count;
        strobe_q <= 1'b1;
        low_q    <= win_low;
        high_q   <= win_high;
        stop_q   <= win_stop;
        if (win_stop) begin
          hyst_q <= '0;
          ok_q   <= 1'b0;
        end else if (win_good) begin
          if (hyst_q == HYST_MAX) ok_q   <= 1'b1;
          else                    hyst_q <= hyst_q + 1'b1;
        end else if (win_bad) begin
          if (hyst_q != '0) hyst_q <= hyst_q - 1'b1;
          else              ok_q   <= 1'b0;
        end
      end
    end
  end

  assign mon.meas_count      = meas_q;
  assign mon.meas_strobe     = strobe_q;
  assign mon.int_freq_ok     = ok_q;
  assign mon.int_freq_low    = low_q;
  assign mon.int_freq_high   = high_q;
  assign mon.int_clk_stopped = stop_q;
  assign mon.hyst_count      = hyst_q;
  assign mon.fsm_state       = state;

endmodule
